// File: rtl/calc_pkg.sv
// Shared types and constants for the calculator operation sequencer.
// The package holds the FSM states, token codes, opcodes and the token-order helper.
package calc_pkg;

  typedef enum logic [2:0] {
    S_A   = 3'd0,
    S_OP  = 3'd1,
    S_B   = 3'd2,
    S_EQ  = 3'd3,
    S_ADD = 3'd4,
    S_NEG = 3'd5,
    S_OUT = 3'd6
  } state_e;

  localparam logic [1:0] TOK_OPERAND  = 2'b00;
  localparam logic [1:0] TOK_OPERATOR = 2'b01;
  localparam logic [1:0] TOK_EQUALS   = 2'b10;
  localparam logic [1:0] TOK_CLEAR    = 2'b11;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  // Token type that advances the FSM from a token-accepting state.
  function automatic logic [1:0] expected_tok(input state_e s);
    logic [1:0] t;
    case (s)
      S_A:     t = TOK_OPERAND;
      S_OP:    t = TOK_OPERATOR;
      S_B:     t = TOK_OPERAND;
      S_EQ:    t = TOK_EQUALS;
      default: t = TOK_CLEAR;
    endcase
    return t;
  endfunction

endpackage

// File: rtl/calc_op_sequencer.sv
// Sequences A/op/B/= tokens onto an external ripple adder and returns a
// sign/magnitude result; a negative difference takes a second negation pass.
module calc_op_sequencer
  import calc_pkg::*;
#(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         tok_valid,
  output logic         tok_ready,
  input  logic [1:0]   tok_type,
  input  logic [W-1:0] tok_data,
  output logic [W-1:0] add_a,
  output logic [W-1:0] add_b,
  output logic         add_cin,
  input  logic [W:0]   add_sum,
  output logic         res_valid,
  input  logic         res_ready,
  output logic [W:0]   res_value,
  output logic         res_neg,
  output logic         err
);

  state_e       state_q, state_d;
  logic [W-1:0] a_q, a_d;
  logic [W-1:0] b_q, b_d;
  logic         op_q, op_d;
  logic [W-1:0] diff_q, diff_d;
  logic         res_valid_q, res_valid_d;
  logic [W:0]   res_value_q, res_value_d;
  logic         res_neg_q, res_neg_d;
  logic         tok_ready_s;
  logic         tok_fire_s;
  logic         err_s;

  // Token handshake decode.
  always_comb begin
    tok_ready_s = 1'b0;
    case (state_q)
      S_A, S_OP, S_B, S_EQ: tok_ready_s = 1'b1;
      default:              tok_ready_s = 1'b0;
    endcase
    tok_fire_s = tok_valid & tok_ready_s;
  end

  // Adder drive; the negate pass computes ~diff + 1.
  always_comb begin
    add_a   = '0;
    add_b   = '0;
    add_cin = 1'b0;
    case (state_q)
      S_ADD: begin
        add_a   = a_q;
        add_b   = (op_q == OP_SUB) ? ~b_q : b_q;
        add_cin = op_q;
      end
      S_NEG: begin
        add_a   = ~diff_q;
        add_b   = '0;
        add_cin = 1'b1;
      end
      default: begin
        add_a   = '0;
        add_b   = '0;
        add_cin = 1'b0;
      end
    endcase
  end

  // Next-state, operand capture and result capture.
  always_comb begin
    state_d     = state_q;
    a_d         = a_q;
    b_d         = b_q;
    op_d        = op_q;
    diff_d      = diff_q;
    res_valid_d = res_valid_q;
    res_value_d = res_value_q;
    res_neg_d   = res_neg_q;
    err_s       = 1'b0;
    case (state_q)
      S_A, S_OP, S_B, S_EQ: begin
        if (!tok_fire_s) begin
          state_d = state_q;
        end else if (tok_type == TOK_CLEAR) begin
          state_d = S_A;
          a_d     = '0;
          b_d     = '0;
          op_d    = OP_ADD;
          diff_d  = '0;
        end else if (tok_type == expected_tok(state_q)) begin
          case (state_q)
            S_A: begin
              a_d     = tok_data;
              state_d = S_OP;
            end
            S_OP: begin
              op_d    = tok_data[0];
              state_d = S_B;
            end
            S_B: begin
              b_d     = tok_data;
              state_d = S_EQ;
            end
            S_EQ:    state_d = S_ADD;
            default: state_d = S_A;
          endcase
        end else begin
          // Out-of-order token is swallowed so the producer never stalls on it.
          err_s = 1'b1;
        end
      end
      S_ADD: begin
        if ((op_q == OP_SUB) && !add_sum[W]) begin
          diff_d  = add_sum[W-1:0];
          state_d = S_NEG;
        end else begin
          res_valid_d = 1'b1;
          res_value_d = (op_q == OP_ADD) ? add_sum : {1'b0, add_sum[W-1:0]};
          res_neg_d   = 1'b0;
          state_d     = S_OUT;
        end
      end
      S_NEG: begin
        res_valid_d = 1'b1;
        res_value_d = {1'b0, add_sum[W-1:0]};
        res_neg_d   = 1'b1;
        state_d     = S_OUT;
      end
      S_OUT: begin
        if (res_ready) begin
          res_valid_d = 1'b0;
          res_value_d = '0;
          res_neg_d   = 1'b0;
          state_d     = S_A;
        end else begin
          state_d = S_OUT;
        end
      end
      default: state_d = S_A;
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_A;
      a_q         <= '0;
      b_q         <= '0;
      op_q        <= OP_ADD;
      diff_q      <= '0;
      res_valid_q <= 1'b0;
      res_value_q <= '0;
      res_neg_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      b_q         <= b_d;
      op_q        <= op_d;
      diff_q      <= diff_d;
      res_valid_q <= res_valid_d;
      res_value_q <= res_value_d;
      res_neg_q   <= res_neg_d;
    end
  end

  assign tok_ready = tok_ready_s;
  assign err       = err_s;
  assign res_valid = res_valid_q;
  assign res_value = res_value_q;
  assign res_neg   = res_neg_q;

endmodule

// File: tb/tb_calc_op_sequencer.sv
// Self-checking bench for calc_op_sequencer with a behavioural adder and
// an arithmetic reference model for result value, sign and latency.
module tb_calc_op_sequencer;
  import calc_pkg::*;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         tok_valid;
  logic         tok_ready;
  logic [1:0]   tok_type;
  logic [W-1:0] tok_data;
  logic [W-1:0] add_a;
  logic [W-1:0] add_b;
  logic         add_cin;
  logic [W:0]   add_sum;
  logic         res_valid;
  logic         res_ready;
  logic [W:0]   res_value;
  logic         res_neg;
  logic         err;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  // Stand-in for the sibling ripple adder.
  assign add_sum = {1'b0, add_a} + {1'b0, add_b} + {{W{1'b0}}, add_cin};

  calc_op_sequencer #(.W(W)) dut (
    .clk(clk), .rst(rst),
    .tok_valid(tok_valid), .tok_ready(tok_ready), .tok_type(tok_type), .tok_data(tok_data),
    .add_a(add_a), .add_b(add_b), .add_cin(add_cin), .add_sum(add_sum),
    .res_valid(res_valid), .res_ready(res_ready), .res_value(res_value), .res_neg(res_neg),
    .err(err)
  );

  typedef struct {
    logic [W-1:0] a;
    logic         op;
    logic [W-1:0] b;
    logic [W:0]   v;
    logic         n;
    int           lat;
    int           hold;
  } vec_t;

  vec_t tbl[7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Signed arithmetic view of the operation: magnitude, sign, cycles to result.
  function automatic void model(input logic [W-1:0] a, input logic op, input logic [W-1:0] b,
                                output logic [W:0] v, output logic n, output int lat);
    int ai = int'(a);
    int bi = int'(b);
    if (op == 1'b0) begin
      v = 9'(ai + bi); n = 1'b0; lat = 2;
    end else if (ai >= bi) begin
      v = 9'(ai - bi); n = 1'b0; lat = 2;
    end else begin
      v = 9'(bi - ai); n = 1'b1; lat = 3;
    end
  endfunction

  task automatic send_tok(input logic [1:0] t, input logic [W-1:0] d, input logic exp_err);
    @(negedge clk);
    tok_valid = 1'b1;
    tok_type  = t;
    tok_data  = d;
    #1;
    check("tok_ready", tok_ready, 1);
    check("err", err, exp_err);
    @(posedge clk);
    #1 tok_valid = 1'b0;
  endtask

  task automatic run_op(input logic [W-1:0] a, input logic op, input logic [W-1:0] b,
                        input logic [W:0] ev, input logic en, input int elat, input int hold);
    int k = 0;
    logic got = 1'b0;
    logic [W-1:0] eb = op ? ~b : b;
    send_tok(TOK_OPERAND, a, 1'b0);
    send_tok(TOK_OPERATOR, {{(W-1){1'b0}}, op}, 1'b0);
    send_tok(TOK_OPERAND, b, 1'b0);
    send_tok(TOK_EQUALS, '0, 1'b0);
    while (!got && k < 10) begin
      @(negedge clk);
      k++;
      if (k == 1) begin
        check("add_a", add_a, a);
        check("add_b", add_b, eb);
        check("add_cin", add_cin, op);
      end
      if (res_valid) got = 1'b1;
      else check("tok_ready_busy", tok_ready, 0);
    end
    check("latency", k, elat);
    check("res_value", res_value, ev);
    check("res_neg", res_neg, en);
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      check("hold_valid", res_valid, 1);
      check("hold_value", res_value, ev);
      check("hold_neg", res_neg, en);
      check("hold_tok_ready", tok_ready, 0);
    end
    res_ready = 1'b1;
    @(posedge clk);
    #1 res_ready = 1'b0;
    @(negedge clk);
    check("valid_drop", res_valid, 0);
    check("back_to_a", tok_ready, 1);
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_res_valid"}, res_valid, 0);
    check({tag, "_res_value"}, res_value, 0);
    check({tag, "_res_neg"}, res_neg, 0);
    check({tag, "_err"}, err, 0);
    check({tag, "_add_a"}, add_a, 0);
    check({tag, "_add_b"}, add_b, 0);
    check({tag, "_add_cin"}, add_cin, 0);
  endtask

  initial begin
    logic [W-1:0] ra, rb;
    logic         rop, rn;
    logic [W:0]   rv;
    int           rlat;

    tbl[0] = '{8'd100, 1'b0, 8'd55,  9'd155, 1'b0, 2, 0};
    tbl[1] = '{8'd200, 1'b0, 8'd100, 9'd300, 1'b0, 2, 1};
    tbl[2] = '{8'd50,  1'b1, 8'd20,  9'd30,  1'b0, 2, 0};
    tbl[3] = '{8'd20,  1'b1, 8'd50,  9'd30,  1'b1, 3, 0};
    tbl[4] = '{8'd0,   1'b1, 8'd0,   9'd0,   1'b0, 2, 0};
    tbl[5] = '{8'd0,   1'b1, 8'd255, 9'd255, 1'b1, 3, 2};
    tbl[6] = '{8'd255, 1'b0, 8'd255, 9'd510, 1'b0, 2, 5};

    rst = 1'b1; tok_valid = 1'b0; tok_type = 2'b00; tok_data = '0; res_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_idle("reset");
    check("reset_tok_ready", tok_ready, 1);
    rst = 1'b0;

    for (int i = 0; i < 7; i++)
      run_op(tbl[i].a, tbl[i].op, tbl[i].b, tbl[i].v, tbl[i].n, tbl[i].lat, tbl[i].hold);

    // Out-of-order tokens and CLEAR recovery.
    send_tok(TOK_EQUALS, '0, 1'b1);
    send_tok(TOK_OPERAND, 8'd7, 1'b0);
    send_tok(TOK_OPERAND, 8'd8, 1'b1);
    send_tok(TOK_CLEAR, '0, 1'b0);
    run_op(8'd9, 1'b0, 8'd1, 9'd10, 1'b0, 2, 0);

    // Reset while the subtraction is on the adder.
    send_tok(TOK_OPERAND, 8'd20, 1'b0);
    send_tok(TOK_OPERATOR, 8'd1, 1'b0);
    send_tok(TOK_OPERAND, 8'd50, 1'b0);
    send_tok(TOK_EQUALS, '0, 1'b0);
    @(negedge clk);
    check("mid_add_cin", add_cin, 1);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check_idle("midrst");
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("midrst_no_valid", res_valid, 0);
    end
    check("midrst_tok_ready", tok_ready, 1);
    run_op(8'd20, 1'b1, 8'd50, 9'd30, 1'b1, 3, 0);

    for (int i = 0; i < 40; i++) begin
      ra  = 8'($urandom_range(0, 255));
      rb  = 8'($urandom_range(0, 255));
      rop = 1'($urandom_range(0, 1));
      model(ra, rop, rb, rv, rn, rlat);
      run_op(ra, rop, rb, rv, rn, rlat, $urandom_range(0, 2));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
